// File: rtl/pl_mem_access.sv
// Data-memory access stage between EX/MEM and MEM/WB: drives a variable-latency
// request/acknowledge bus, stalls the front of the pipeline and gates write-back on faults.
module pl_mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  output logic        owreg,
  output logic        om2reg,
  output logic [31:0] mrno,
  output logic [4:0]  orn,
  output logic        mstall,
  output logic        merr,
  output logic [31:0] merr_addr,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  input  logic [31:0] drdata,
  input  logic        dack,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        to_q, to_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] daddr_q, daddr_d;
  logic [31:0] dwdata_q, dwdata_d;
  logic        dwe_q, dwe_d;
  logic        merr_q, merr_d;
  logic [31:0] merr_addr_q, merr_addr_d;

  logic       memop, mis;
  logic [7:0] cnt_inc;

  assign memop   = mm2reg | mwmem;
  assign mis     = memop & (malu[1:0] != 2'b00);
  assign cnt_inc = cnt_q + 8'd1;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      to_q        <= 1'b0;
      rdata_q     <= '0;
      daddr_q     <= '0;
      dwdata_q    <= '0;
      dwe_q       <= 1'b0;
      merr_q      <= 1'b0;
      merr_addr_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      rdata_q     <= rdata_d;
      daddr_q     <= daddr_d;
      dwdata_q    <= dwdata_d;
      dwe_q       <= dwe_d;
      merr_q      <= merr_d;
      merr_addr_q <= merr_addr_d;
    end
  end

  // Bus handshake: dreq is held high with daddr/dwe/dwdata stable for the whole
  // REQ interval; the slave answers with a single-cycle dack, which is only
  // honoured in REQ. An ack arriving on the timeout cycle still completes normally.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    rdata_d     = rdata_q;
    daddr_d     = daddr_q;
    dwdata_d    = dwdata_q;
    dwe_d       = dwe_q;
    merr_d      = merr_q;
    merr_addr_d = merr_addr_q;
    case (state_q)
      S_IDLE: begin
        if (mis) begin
          if (!merr_q) begin
            merr_d      = 1'b1;
            merr_addr_d = malu;
          end
        end else if (memop) begin
          daddr_d  = {malu[31:2], 2'b00};
          dwdata_d = mb;
          dwe_d    = mwmem;
          cnt_d    = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (dack) begin
          rdata_d = dwe_q ? 32'd0 : drdata;
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (cnt_inc == TO_CNT) begin
          rdata_d = '0;
          to_d    = 1'b1;
          cnt_d   = '0;
          if (!merr_q) begin
            merr_d      = 1'b1;
            merr_addr_d = daddr_q;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        to_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A stalled cycle hands MEM/WB a bubble; a misaligned access is dropped in place.
  always_comb begin
    owreg  = 1'b0;
    om2reg = 1'b0;
    mrno   = '0;
    mstall = 1'b0;
    dreq   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memop && !mis) mstall = 1'b1;
        else if (!memop)   owreg  = mwreg;
      end
      S_REQ: begin
        dreq   = 1'b1;
        mstall = 1'b1;
      end
      S_DONE: begin
        mrno   = rdata_q;
        owreg  = mwreg & ~to_q;
        om2reg = mm2reg & ~to_q;
      end
      default: ;
    endcase
  end

  assign orn       = mrn;
  assign dwe       = dwe_q;
  assign daddr     = daddr_q;
  assign dwdata    = dwdata_q;
  assign merr      = merr_q;
  assign merr_addr = merr_addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pl_mem_access.sv
// Bench for pl_mem_access: instruction driver with a built-in bus slave, a retirement
// scoreboard for write-back results, and a sticky-fault reference model.
module tb_pl_mem_access;

  localparam int TO = 6;

  logic        clock = 1'b0;
  logic        reset;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] malu, mb;
  logic [4:0]  mrn;
  logic        owreg, om2reg;
  logic [31:0] mrno;
  logic [4:0]  orn;
  logic        mstall, merr;
  logic [31:0] merr_addr;
  logic        dreq, dwe;
  logic [31:0] daddr, dwdata, drdata;
  logic        dack;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];
  logic        m_err;
  logic [31:0] m_addr;
  logic [15:0] stall_log;

  pl_mem_access #(.TIMEOUT(TO)) u_dut (
    .clock(clock), .reset(reset), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu(malu), .mb(mb), .mrn(mrn), .owreg(owreg), .om2reg(om2reg), .mrno(mrno),
    .orn(orn), .mstall(mstall), .merr(merr), .merr_addr(merr_addr), .dreq(dreq),
    .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .drdata(drdata), .dack(dack),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one instruction and act as the bus slave; ack_at = REQ cycle that acks (0 = never).
  task automatic issue(input logic wreg, input logic m2reg, input logic wmem,
                       input logic [31:0] alu, input logic [31:0] b,
                       input logic [31:0] rd, input int ack_at);
    logic        memop, mis, tmo, eow, eom, retired;
    logic [31:0] emr;
    logic [33:0] e;
    int          n, estall, ereq, stallc, reqc;
    memop = m2reg | wmem;
    mis   = memop && (alu[1:0] != 2'b00);
    tmo   = 1'b0;
    n     = 0;
    eow   = 1'b0;
    eom   = 1'b0;
    emr   = '0;
    if (!memop) begin
      eow = wreg;
    end else if (mis) begin
      if (!m_err) begin m_err = 1'b1; m_addr = alu; end
    end else begin
      tmo = !(ack_at >= 1 && ack_at <= TO);
      n   = tmo ? TO : ack_at;
      if (tmo) begin
        if (!m_err) begin m_err = 1'b1; m_addr = alu; end
      end else begin
        eow = wreg;
        eom = m2reg;
        emr = wmem ? 32'd0 : rd;
      end
    end
    ereq   = n;
    estall = (memop && !mis) ? n + 1 : 0;
    exp_q.push_back({eow, eom, emr});

    mwreg  = wreg; mm2reg = m2reg; mwmem = wmem;
    malu   = alu;  mb = b;  drdata = rd;
    mrn    = 5'($urandom_range(0, 31));
    stallc = 0; reqc = 0; retired = 1'b0;
    for (int cyc = 0; cyc < 40 && !retired; cyc++) begin
      @(negedge clock);
      stall_log = {stall_log[14:0], mstall};
      check("orn", 32'(orn), 32'(mrn));
      if (dreq) begin
        reqc++;
        check("daddr", daddr, {alu[31:2], 2'b00});
        check("dwdata", dwdata, b);
        check("dwe", 32'(dwe), 32'(wmem));
        dack = (reqc == ack_at);
      end
      if (mstall) begin
        stallc++;
        check("owreg_bubble", 32'(owreg), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("owreg", 32'(owreg), 32'(e[33]));
        check("om2reg", 32'(om2reg), 32'(e[32]));
        check("mrno", mrno, e[31:0]);
        retired = 1'b1;
      end
      @(posedge clock);
      #1 dack = 1'b0;
    end
    if (!retired) check("retire_timeout", 32'd0, 32'd1);
    check("stall_cycles", 32'(stallc), 32'(estall));
    check("req_cycles", 32'(reqc), 32'(ereq));
    check("merr", 32'(merr), 32'(m_err));
    check("merr_addr", merr_addr, m_addr);
  endtask

  initial begin
    reset = 1'b1; mwreg = 0; mm2reg = 0; mwmem = 0; malu = '0; mb = '0; mrn = '0;
    drdata = '0; dack = 1'b0; stall_log = '0; m_err = 1'b0; m_addr = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_dreq", 32'(dreq), 32'd0);
    check("rst_mstall", 32'(mstall), 32'd0);
    check("rst_mrno", mrno, 32'd0);
    check("rst_merr", 32'(merr), 32'd0);
    check("rst_merr_addr", merr_addr, 32'd0);
    check("rst_daddr", daddr, 32'd0);
    check("rst_dwdata", dwdata, 32'd0);
    check("rst_dwe", 32'(dwe), 32'd0);
    @(posedge clock);
    #1;

    issue(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    check("load_daddr_held", daddr, 32'h100);
    check("load_dwe_held", 32'(dwe), 32'd0);
    issue(1'b0, 1'b0, 1'b1, 32'h204, 32'h12345678, 32'hFFFFFFFF, 5);
    issue(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 32'h0, 0);
    issue(1'b1, 1'b1, 1'b0, 32'h208, 32'h0, 32'hA5A5A5A5, TO);
    issue(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 32'hCAFE0001, 0);

    // Reset lands in the second REQ cycle of an access the slave never acks.
    mwreg = 1'b1; mm2reg = 1'b1; mwmem = 1'b0; malu = 32'h400; dack = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    mm2reg = 1'b0; malu = 32'h7;
    m_err = 1'b0; m_addr = '0;
    @(negedge clock);
    check("rstreq_dreq", 32'(dreq), 32'd0);
    check("rstreq_state", 32'(dbg_state), 32'd0);
    check("rstreq_merr", 32'(merr), 32'd0);
    check("rstreq_mstall", 32'(mstall), 32'd0);
    check("rstreq_owreg", 32'(owreg), 32'd1);
    @(posedge clock);
    #1;

    issue(1'b1, 1'b1, 1'b0, 32'h103, 32'h0, 32'h11111111, 1);
    issue(1'b1, 1'b0, 1'b1, 32'h106, 32'h0, 32'h0, 1);

    stall_log = '0;
    issue(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 0);
    issue(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 32'h01020304, 1);
    issue(1'b1, 1'b1, 1'b0, 32'h24, 32'h0, 32'h0A0B0C0D, 1);
    issue(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 32'h0, 0);
    check("seq_stall_pattern", 32'(stall_log[7:0]), 32'h6C);

    for (int i = 0; i < 12; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      case (kind)
        0: issue(1'($urandom_range(0, 1)), 1'b0, 1'b0, a, $urandom, $urandom, 0);
        1: issue(1'b1, 1'b1, 1'b0, a, $urandom, $urandom, $urandom_range(0, TO));
        2: issue(1'b0, 1'b0, 1'b1, a, $urandom, $urandom, $urandom_range(0, TO));
        default: issue(1'b1, 1'b1, 1'b0, a | 32'($urandom_range(1, 3)), $urandom, $urandom, 1);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
